// File: rtl/lc3_bus_pkg.sv
// Shared SLC-3 bus definitions: driver indices, one-hot gate codes and arbiter state.
package lc3_bus_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned SRC_W   = 2;
  localparam int unsigned HOLD_W  = 4;

  localparam logic [SRC_W-1:0] SRC_PC     = 2'd3;
  localparam logic [SRC_W-1:0] SRC_MDR    = 2'd2;
  localparam logic [SRC_W-1:0] SRC_ALU    = 2'd1;
  localparam logic [SRC_W-1:0] SRC_MARMUX = 2'd0;

  localparam logic [NUM_SRC-1:0] GATE_PC     = 4'b1000;
  localparam logic [NUM_SRC-1:0] GATE_MDR    = 4'b0100;
  localparam logic [NUM_SRC-1:0] GATE_ALU    = 4'b0010;
  localparam logic [NUM_SRC-1:0] GATE_MARMUX = 4'b0001;
  localparam logic [NUM_SRC-1:0] GATE_NONE   = 4'b0000;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  function automatic logic [NUM_SRC-1:0] gate_of(input logic [SRC_W-1:0] idx);
    return NUM_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_gate_arbiter_if.sv
// Bus-request/gate bundle between the bus drivers and the gate arbiter.
interface bus_gate_arbiter_if;
  import lc3_bus_pkg::*;

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] last;
  logic [NUM_SRC-1:0] gate;
  logic [SRC_W-1:0]   grant_id;
  logic               busy;

  modport master (
    output req,
    output last,
    input  gate,
    input  grant_id,
    input  busy
  );

  modport slave (
    input  req,
    input  last,
    output gate,
    output grant_id,
    output busy
  );
endinterface

// File: rtl/bus_gate_arbiter_rr_pick4.sv
// Combinational round-robin pick; order PC->MDR->ALU->MARMUX, starting after last_winner.
module rr_pick4
  import lc3_bus_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   last_winner,
  output logic               valid_c,
  output logic [SRC_W-1:0]   idx_c
);

  // Walk from lowest priority (the last winner itself) up to the highest so the
  // final hit is the one just after the last winner in descending-index order.
  always_comb begin
    valid_c = 1'b0;
    idx_c   = SRC_MARMUX;
    for (int i = 4; i >= 1; i--) begin
      if (req[SRC_W'(last_winner - SRC_W'(i))]) begin
        valid_c = 1'b1;
        idx_c   = SRC_W'(last_winner - SRC_W'(i));
      end
    end
  end

endmodule

// File: rtl/bus_gate_arbiter.sv
// Round-robin owner of the shared datapath bus; drives the registered one-hot gate select.
module bus_gate_arbiter
  import lc3_bus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  bus_gate_arbiter_if.slave   bus
);

  arb_state_e          state_q, state_d;
  logic [NUM_SRC-1:0]  gate_q, gate_d;
  logic [SRC_W-1:0]    grant_id_q, grant_id_d;
  logic                busy_q, busy_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [SRC_W-1:0]    ptr_q, ptr_d;

  logic [NUM_SRC-1:0]  others;
  logic [NUM_SRC-1:0]  pick_req;
  logic                own_req;
  logic                own_last;
  logic                hold_full;
  logic                release_c;
  logic                pick_valid;
  logic [SRC_W-1:0]    pick_idx;

  // gate_q is one-hot of the owner, so it doubles as the owner mask.
  always_comb begin
    others    = bus.req & ~gate_q;
    own_req   = |(bus.req & gate_q);
    own_last  = |(bus.req & bus.last & gate_q);
    hold_full = (hold_q == HOLD_W'(MAX_HOLD));
    release_c = own_last || !own_req || (hold_full && (|others));
    pick_req  = (state_q == OWN) ? others : bus.req;
  end

  rr_pick4 u_pick (
    .req         (pick_req),
    .last_winner (ptr_q),
    .valid_c     (pick_valid),
    .idx_c       (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    hold_d     = hold_q;
    ptr_d      = ptr_q;

    if ((state_q == IDLE) || release_c) begin
      if (pick_valid) begin
        state_d    = OWN;
        gate_d     = gate_of(pick_idx);
        grant_id_d = pick_idx;
        busy_d     = 1'b1;
        hold_d     = HOLD_W'(1);
        ptr_d      = pick_idx;
      end else begin
        state_d    = IDLE;
        gate_d     = GATE_NONE;
        grant_id_d = SRC_MARMUX;
        busy_d     = 1'b0;
        hold_d     = '0;
      end
    end else if (!hold_full) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      gate_q     <= GATE_NONE;
      grant_id_q <= SRC_MARMUX;
      busy_q     <= 1'b0;
      hold_q     <= '0;
      ptr_q      <= SRC_MARMUX;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      hold_q     <= hold_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.gate     = gate_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;

endmodule
